// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_wr_arbiter_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_LEN  = 8;
    localparam int DEF_ID_W      = 2;
    localparam int DEF_MAX_BURST = 8;

    // Arbiter FSM: IDLE has no owner, HOLD has a registered owner.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set valid bit at or above ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic             hit,
    output logic [ID_W-1:0]  idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] rot;
    int                 sum;

    // Rotate the valid vector so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        sum = 0;
        dbl = {valid, valid};
        rot = dbl >> ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit && rot[k]) begin
                hit = 1'b1;
                sum = int'(ptr) + k;
                if (sum >= N_REQ) begin
                    sum = sum - N_REQ;
                end
                idx = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting bursts from N_REQ requesters into one sync FIFO.
// Latency: one-cycle arbitration bubble on grant; beats then pass to the FIFO combinationally.
// Backpressure: fifo_full deasserts the owner's req_ready and stalls the burst in place.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_LEN  = DEF_DATA_LEN,
    parameter int ID_W      = DEF_ID_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      sys_rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_LEN-1:0] req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [ID_W+DATA_LEN-1:0]  fifo_data_in,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [ID_W-1:0]     owner;
    logic [ID_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]    beat_cnt;
    logic                pick_hit;
    logic [ID_W-1:0]     pick_idx;
    logic                own_valid;
    logic                own_last;
    logic [DATA_LEN-1:0] own_data;
    logic                burst_end;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );

    // Select the owner's valid, last and payload lanes.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == ID_W'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    // Handshake outputs: only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (state == HOLD && !fifo_full) begin
            req_ready = N_REQ'(1) << owner;
        end
        fifo_wr_en   = (state == HOLD) && !fifo_full && own_valid;
        fifo_data_in = {owner, own_data};
        busy         = (state == HOLD);
        grant_id     = (state == HOLD) ? owner : '0;
        burst_end    = fifo_wr_en && (own_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));
    end

    // Next state: grant on any valid in IDLE, release on the closing beat of a burst.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_hit)  state_nxt = HOLD;
            HOLD:    if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner capture, beat counting and round-robin pointer advance.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_hit) begin
                owner    <= pick_idx;
                beat_cnt <= '0;
            end
        end else if (fifo_wr_en) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (burst_end) begin
                rr_ptr <= (owner == ID_W'(N_REQ - 1)) ? '0 : owner + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences, random vs model.
// Latency: inputs change 1ns after the rising edge, outputs are sampled mid-cycle.
// Backpressure: fifo_full is driven directly by the stimulus.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DL = 8;
    localparam int IW = 2;
    localparam int MB = 8;

    logic              clk;
    logic              sys_rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DL-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [IW+DL-1:0]  fifo_data_in;
    logic              busy;
    logic [IW-1:0]     grant_id;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DATA_LEN  (DL),
        .ID_W      (IW),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  e_ready;
        logic        e_wr;
        logic [9:0]  e_dat;
        logic        e_busy;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after a rising edge with reset released and inputs idle.
    task automatic do_reset;
        sys_rst_n = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // Reference model state: grant bookkeeping in plain integers.
    int m_busy, m_owner, m_cnt, m_ptr;

    initial begin
        int k;
        int q[$];
        int found;
        int j;
        logic [3:0] e_rdy;
        logic       e_wr;

        // ---------------- reset state ----------------
        sys_rst_n = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'h000000A5;
        fifo_full = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_wr", fifo_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_data", fifo_data_in, 10'h0A5);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_wr", fifo_wr_en, 0);
        chk("rst_hold_busy", busy, 0);

        // ---------------- vector table ----------------
        tbl[0]  = '{4'b0010, 32'h00001100, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0010, 32'h00001100, 4'b0000, 1'b0, 4'b0010, 1'b1, 10'h111, 1'b1, 2'd1};
        tbl[2]  = '{4'b0010, 32'h00002200, 4'b0000, 1'b0, 4'b0010, 1'b1, 10'h122, 1'b1, 2'd1};
        tbl[3]  = '{4'b0010, 32'h00003300, 4'b0010, 1'b0, 4'b0010, 1'b1, 10'h133, 1'b1, 2'd1};
        tbl[4]  = '{4'b0000, 32'h44332211, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0};
        tbl[5]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0};
        tbl[6]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b0, 4'b0100, 1'b1, 10'h233, 1'b1, 2'd2};
        tbl[7]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0};
        tbl[8]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b0, 4'b1000, 1'b1, 10'h344, 1'b1, 2'd3};
        tbl[9]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0};
        tbl[10] = '{4'b1111, 32'h44332211, 4'b1111, 1'b1, 4'b0000, 1'b0, 10'h000, 1'b1, 2'd0};
        tbl[11] = '{4'b1111, 32'h44332211, 4'b1111, 1'b0, 4'b0001, 1'b1, 10'h011, 1'b1, 2'd0};
        tbl[12] = '{4'b0000, 32'h44332211, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0};

        do_reset;
        for (int i = 0; i < 13; i++) begin
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            req_last  = tbl[i].last;
            fifo_full = tbl[i].full;
            #4;
            chk("tbl_ready", req_ready, tbl[i].e_ready);
            chk("tbl_wr", fifo_wr_en, tbl[i].e_wr);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_gid", grant_id, tbl[i].e_gid);
            if (tbl[i].e_wr) chk("tbl_data", fifo_data_in, tbl[i].e_dat);
            next_cycle;
        end

        // ---------------- round-robin order 0,1,2,3,0 with bubbles ----------------
        do_reset;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'h44332211;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (c % 2 == 1) begin
                chk("rr_wr", fifo_wr_en, 1);
                chk("rr_gid", grant_id, (c / 2) % 4);
            end else begin
                chk("rr_bubble", busy, 0);
            end
            next_cycle;
        end

        // ---------------- MAX_BURST cut-off ----------------
        do_reset;
        req_valid = 4'b1100;
        req_last  = 4'b0000;
        req_data  = 32'h44332211;
        for (int c = 0; c < 11; c++) begin
            #4;
            if (c >= 1 && c <= 8) begin
                chk("mb_wr", fifo_wr_en, 1);
                chk("mb_gid", grant_id, 2);
            end
            if (c == 9)  chk("mb_release", busy, 0);
            if (c == 10) begin
                chk("mb_next_gid", grant_id, 3);
                chk("mb_next_wr", fifo_wr_en, 1);
            end
            next_cycle;
        end

        // ---------------- fifo_full stall mid-burst ----------------
        do_reset;
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        k = 1;
        q.delete();
        for (int c = 0; c < 15; c++) begin
            fifo_full = (c >= 3 && c <= 7);
            req_data  = 32'(k) << 8;
            #4;
            if (fifo_full) begin
                chk("stall_wr", fifo_wr_en, 0);
                chk("stall_ready", req_ready, 0);
                chk("stall_busy", busy, 1);
            end
            if (fifo_wr_en) begin
                q.push_back(int'(fifo_data_in[7:0]));
                k++;
            end
            if (c == 14) chk("stall_end_idle", busy, 0);
            next_cycle;
        end
        fifo_full = 1'b0;
        chk("stall_beats", q.size(), 8);
        for (int i = 0; i < q.size(); i++) chk("stall_order", q[i], i + 1);

        // ---------------- reset mid-burst ----------------
        do_reset;
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data  = 32'h0055005A;
        for (int c = 0; c < 5; c++) begin
            #4;
            if (c >= 1) chk("mrst_beat", fifo_wr_en, 1);
            if (c < 4) next_cycle;
        end
        sys_rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_wr", fifo_wr_en, 0);
        chk("mrst_ready", req_ready, 0);
        chk("mrst_gid", grant_id, 0);
        chk("mrst_data", fifo_data_in, 10'h05A);
        @(posedge clk);
        #1;
        chk("mrst_edge_wr", fifo_wr_en, 0);
        req_valid = 4'b1001;
        sys_rst_n = 1'b1;
        #4;
        chk("mrst_bubble", busy, 0);
        next_cycle;
        #4;
        chk("mrst_regrant_gid", grant_id, 0);
        chk("mrst_regrant_wr", fifo_wr_en, 1);
        chk("mrst_regrant_data", fifo_data_in, 10'h05A);
        next_cycle;

        // ---------------- owner drops valid mid-burst ----------------
        do_reset;
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        req_data  = 32'h00000077;
        for (int c = 0; c < 7; c++) begin
            if (c >= 3 && c <= 5) req_valid = 4'b1110;
            if (c == 6)           req_valid = 4'b1111;
            #4;
            if (c >= 3 && c <= 5) begin
                chk("drop_busy", busy, 1);
                chk("drop_gid", grant_id, 0);
                chk("drop_wr", fifo_wr_en, 0);
                chk("drop_ready", req_ready, 4'b0001);
            end
            if (c == 6) begin
                chk("drop_resume_wr", fifo_wr_en, 1);
                chk("drop_resume_data", fifo_data_in, 10'h077);
            end
            next_cycle;
        end

        // ---------------- random traffic against reference model ----------------
        do_reset;
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        for (int c = 0; c < 3000; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            for (int b = 0; b < N; b++) req_last[b] = ($urandom_range(0, 3) == 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            #4;
            e_rdy = (m_busy != 0 && !fifo_full) ? 4'(1 << m_owner) : 4'b0000;
            e_wr  = (m_busy != 0) && !fifo_full && req_valid[m_owner];
            chk("rnd_ready", req_ready, e_rdy);
            chk("rnd_wr", fifo_wr_en, e_wr);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_gid", grant_id, (m_busy != 0) ? m_owner : 0);
            if (e_wr) chk("rnd_data", fifo_data_in, {IW'(m_owner), req_data[m_owner*DL +: DL]});
            // Model transition for the coming edge.
            if (m_busy == 0) begin
                found = 0;
                for (int s = 0; s < N; s++) begin
                    j = (m_ptr + s) % N;
                    if (found == 0 && req_valid[j]) begin
                        found   = 1;
                        m_busy  = 1;
                        m_owner = j;
                        m_cnt   = 0;
                    end
                end
            end else if (e_wr) begin
                m_cnt++;
                if (req_last[m_owner] || m_cnt == MB) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
            next_cycle;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of write requesters sharing one sync FIFO.
REQ-002 Parameter DATA_LEN, default 8, payload width per requester.
REQ-003 Parameter ID_W, default 2, requester tag width; SHALL satisfy 2^ID_W >= N_REQ.
REQ-004 Parameter MAX_BURST, default 8, maximum beats per grant; SHALL be >= 1.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  N_REQ  per-requester beat valid.
REQ-008 req_data  input  N_REQ*DATA_LEN  packed payloads; requester i at bits [i*DATA_LEN +: DATA_LEN].
REQ-009 req_last  input  N_REQ  per-requester end-of-burst marker, qualified by valid.
REQ-010 req_ready  output  N_REQ  per-requester accept; beat transfers when valid&ready.
REQ-011 fifo_full  input  1  full flag of the downstream FIFO.
REQ-012 fifo_wr_en  output  1  write strobe to the downstream FIFO.
REQ-013 fifo_data_in  output  ID_W+DATA_LEN  {owner id, payload} written to the FIFO.
REQ-014 busy  output  1  high while a grant is held.
REQ-015 grant_id  output  ID_W  current owner index; 0 when not busy.

Function
REQ-016 FSM SHALL have two states: IDLE (no owner) and HOLD (owner registered).
REQ-017 IDLE -> HOLD on any req_valid high; owner = first requester with valid high searching from rr_ptr upward, modulo N_REQ.
REQ-018 Owner selection is registered: first beat accepted earliest one cycle after valid asserts in IDLE (1-cycle arbitration bubble).
REQ-019 In HOLD, req_ready[owner] = !fifo_full; all other req_ready bits = 0; in IDLE all req_ready = 0.
REQ-020 fifo_wr_en = req_valid[owner] & req_ready[owner], combinational, zero latency; fifo_data_in = {owner, req_data[owner]} combinational.
REQ-021 fifo_wr_en SHALL never assert while fifo_full is high.
REQ-022 Beat counter (width clog2(MAX_BURST)+1) clears on HOLD entry, increments per transferred beat.
REQ-023 HOLD -> IDLE on a transferred beat with req_last[owner]=1 or with beat count == MAX_BURST-1; rr_ptr <= (owner+1) mod N_REQ on that edge.
REQ-024 Owner dropping valid mid-burst SHALL keep HOLD with no timeout; grant is not revoked.
REQ-025 fifo_full high in HOLD stalls the burst; beat count and owner unchanged.
REQ-026 Simultaneous valids in IDLE resolved solely by rr_ptr rotation; no fixed priority.
REQ-027 Fairness: with fifo_full low and all requesters continuously valid, each requester is granted within N_REQ-1 grants of its previous grant.
REQ-028 MAX_BURST=1: every beat ends the grant; throughput one beat per two cycles.

Reset
REQ-029 sys_rst_n low SHALL asynchronously force IDLE, rr_ptr=0, beat count=0, owner=0.
REQ-030 During/after reset: req_ready=0, fifo_wr_en=0, busy=0, grant_id=0; fifo_data_in follows REQ-020 with owner=0.
REQ-031 Reset asserted mid-burst SHALL drop the burst; no write issued on the reset edge; first grant after release uses rr_ptr=0.

Structure
REQ-032 Shared package SHALL hold FSM state encoding (IDLE, HOLD) and default constants N_REQ, DATA_LEN, ID_W, MAX_BURST.
REQ-033 Round-robin search SHALL be one combinational sub-module rr_pick (inputs valid vector and rr_ptr; outputs hit and index); sequential logic stays in fifo_wr_arbiter.

Verification
REQ-034 Single requester: req_valid=4'b0010, 3 beats 0x11,0x22,0x33 with last on beat 3 -> grant_id=1, fifo_data_in 0x111,0x122,0x133 on consecutive cycles, then IDLE, rr_ptr=2.
REQ-035 All four valid continuously, last every beat, rr_ptr=0 -> grant order 0,1,2,3,0; one idle cycle between grants.
REQ-036 Requester 2 streams 20 beats no last, MAX_BURST=8 -> grant ends after 8 beats; requester 3 (valid) gets next grant.
REQ-037 fifo_full high for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 those cycles; data order and beat count preserved after release.
REQ-038 sys_rst_n pulsed low mid-burst at beat 4 -> outputs zero immediately; after release, with req_valid=4'b1001, grant goes to requester 0.
REQ-039 Owner valid drops for 3 cycles mid-burst while others valid -> busy stays 1, grant_id unchanged, no other requester written.
